// File: rtl/execute_jump_redirect.sv
// Execute-stage jump redirect: turns accepted jumps into a fetch redirect handshake plus
// frontend flush, and issues branch-predictor training pulses with saturating hit/miss counters.
module execute_jump_redirect #(
  parameter int unsigned FLUSH_DRAIN_CYCLES = 2,
  parameter int unsigned CNT_W              = 32
) (
  input  logic             iCLOCK,
  input  logic             inRESET,
  input  logic             iRESET_SYNC,
  input  logic             iEVENT_HOLD,
  input  logic             iEVENT_END,
  input  logic             iPREV_PREDICT_ENA,
  input  logic             iPREV_PREDICT_HIT,
  input  logic             iPREV_JUMP_VALID,
  input  logic [31:0]      iPREV_JUMP_ADDR,
  input  logic             iPREV_NORMAL_JUMP_INST,
  input  logic             iPREV_TYPE_BRANCH_VALID,
  input  logic             iPREV_TYPE_BRANCH_IB_VALID,
  input  logic             iPREV_TYPE_SYSREG_IDT_VALID,
  input  logic             iPREV_TYPE_SYSREG_PDT_VALID,
  input  logic             iPREV_TYPE_SYSREG_PSR_VALID,
  output logic             oPREV_BUSY,
  output logic             oFETCH_REDIRECT_VALID,
  output logic [31:0]      oFETCH_REDIRECT_ADDR,
  output logic [2:0]       oFETCH_REDIRECT_KIND,
  input  logic             iFETCH_REDIRECT_ACK,
  output logic             oPIPELINE_FLUSH,
  output logic             oBPRED_UPDATE_VALID,
  output logic             oBPRED_UPDATE_HIT,
  output logic [CNT_W-1:0] oPERF_HIT_CNT,
  output logic [CNT_W-1:0] oPERF_MISS_CNT
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_REDIRECT = 2'd1;
  localparam logic [1:0] ST_DRAIN    = 2'd2;
  localparam logic [1:0] ST_RECOVER  = 2'd3;

  localparam logic [3:0] DRAIN_LOAD = 4'(FLUSH_DRAIN_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [3:0]       drain_q, drain_d;
  logic [31:0]      addr_q, addr_d;
  logic [2:0]       kind_q, kind_d;
  logic             upd_q, upd_d;
  logic             hit_q, hit_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] mcnt_q, mcnt_d;

  logic       jump_req;
  logic [2:0] kind_sel;
  logic       train;

  // Kind 0 is the fall-through encoding, so the plain branch type bit adds nothing.
  logic unused_branch_type;
  assign unused_branch_type = iPREV_TYPE_BRANCH_VALID;

  assign jump_req = iPREV_JUMP_VALID | iPREV_TYPE_BRANCH_IB_VALID | iPREV_TYPE_SYSREG_IDT_VALID
                  | iPREV_TYPE_SYSREG_PDT_VALID | iPREV_TYPE_SYSREG_PSR_VALID;
  assign train    = iPREV_PREDICT_ENA & ~iPREV_NORMAL_JUMP_INST;

  always_comb begin
    if (iPREV_TYPE_SYSREG_PSR_VALID)      kind_sel = 3'd4;
    else if (iPREV_TYPE_SYSREG_PDT_VALID) kind_sel = 3'd3;
    else if (iPREV_TYPE_SYSREG_IDT_VALID) kind_sel = 3'd2;
    else if (iPREV_TYPE_BRANCH_IB_VALID)  kind_sel = 3'd1;
    else                                  kind_sel = 3'd0;
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    addr_d  = addr_q;
    kind_d  = kind_q;
    upd_d   = 1'b0;
    hit_d   = 1'b0;
    hcnt_d  = hcnt_q;
    mcnt_d  = mcnt_q;
    if (iRESET_SYNC) begin
      state_d = ST_IDLE;
      drain_d = '0;
      addr_d  = '0;
      kind_d  = '0;
      hcnt_d  = '0;
      mcnt_d  = '0;
    end else if (iEVENT_HOLD || iEVENT_END) begin
      state_d = ST_IDLE;
      drain_d = '0;
      addr_d  = '0;
      kind_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (train) begin
            upd_d = 1'b1;
            hit_d = iPREV_PREDICT_HIT;
            if (iPREV_PREDICT_HIT) begin
              if (hcnt_q != '1) hcnt_d = hcnt_q + 1'b1;
            end else begin
              if (mcnt_q != '1) mcnt_d = mcnt_q + 1'b1;
            end
          end
          if (jump_req) begin
            addr_d  = iPREV_JUMP_ADDR;
            kind_d  = kind_sel;
            state_d = ST_REDIRECT;
          end
        end
        ST_REDIRECT: begin
          if (iFETCH_REDIRECT_ACK) begin
            state_d = ST_DRAIN;
            drain_d = DRAIN_LOAD;
          end
        end
        ST_DRAIN: begin
          if (drain_q == '0) state_d = ST_RECOVER;
          else               drain_d = drain_q - 1'b1;
        end
        // Inputs here belong to the squashed younger instruction and are dropped.
        ST_RECOVER: state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state_q <= ST_IDLE;
      drain_q <= '0;
      addr_q  <= '0;
      kind_q  <= '0;
      upd_q   <= 1'b0;
      hit_q   <= 1'b0;
      hcnt_q  <= '0;
      mcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      addr_q  <= addr_d;
      kind_q  <= kind_d;
      upd_q   <= upd_d;
      hit_q   <= hit_d;
      hcnt_q  <= hcnt_d;
      mcnt_q  <= mcnt_d;
    end
  end

  assign oPREV_BUSY            = (state_q == ST_REDIRECT) || (state_q == ST_DRAIN);
  assign oFETCH_REDIRECT_VALID = (state_q == ST_REDIRECT);
  assign oPIPELINE_FLUSH       = (state_q == ST_REDIRECT) || (state_q == ST_DRAIN);
  assign oFETCH_REDIRECT_ADDR  = addr_q;
  assign oFETCH_REDIRECT_KIND  = kind_q;
  assign oBPRED_UPDATE_VALID   = upd_q;
  assign oBPRED_UPDATE_HIT     = hit_q;
  assign oPERF_HIT_CNT         = hcnt_q;
  assign oPERF_MISS_CNT        = mcnt_q;

endmodule

// File: tb/tb_execute_jump_redirect.sv
// Self-checking bench for execute_jump_redirect: directed scenarios plus random traffic
// compared cycle by cycle against a behavioural model (default and 4-bit counter instances).
module tb_execute_jump_redirect;

  localparam int unsigned DRAIN_N = 2;

  logic        clk = 1'b0;
  logic        rst_n, rs, ev_hold, ev_end, p_ena, p_hit, jv, njump;
  logic        t_br, t_ib, t_idt, t_pdt, t_psr, ack;
  logic [31:0] jaddr;

  logic        d_busy, d_valid, d_flush, d_upd, d_hit;
  logic [31:0] d_addr;
  logic [2:0]  d_kind;
  logic [31:0] d_hcnt, d_mcnt;
  logic        s_busy, s_valid, s_flush, s_upd, s_hit;
  logic [31:0] s_addr;
  logic [2:0]  s_kind;
  logic [3:0]  s_hcnt, s_mcnt;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // model state
  bit          m_red, m_rec, m_upd, m_hit;
  int unsigned m_drain;
  logic [31:0] m_addr;
  logic [2:0]  m_kind;
  int unsigned m_hits, m_miss;

  int unsigned obs_valid, obs_flush, obs_upd;

  always #5 clk = ~clk;

  execute_jump_redirect #(.FLUSH_DRAIN_CYCLES(DRAIN_N), .CNT_W(32)) u_dut (
    .iCLOCK(clk), .inRESET(rst_n), .iRESET_SYNC(rs), .iEVENT_HOLD(ev_hold), .iEVENT_END(ev_end),
    .iPREV_PREDICT_ENA(p_ena), .iPREV_PREDICT_HIT(p_hit), .iPREV_JUMP_VALID(jv),
    .iPREV_JUMP_ADDR(jaddr), .iPREV_NORMAL_JUMP_INST(njump), .iPREV_TYPE_BRANCH_VALID(t_br),
    .iPREV_TYPE_BRANCH_IB_VALID(t_ib), .iPREV_TYPE_SYSREG_IDT_VALID(t_idt),
    .iPREV_TYPE_SYSREG_PDT_VALID(t_pdt), .iPREV_TYPE_SYSREG_PSR_VALID(t_psr),
    .oPREV_BUSY(d_busy), .oFETCH_REDIRECT_VALID(d_valid), .oFETCH_REDIRECT_ADDR(d_addr),
    .oFETCH_REDIRECT_KIND(d_kind), .iFETCH_REDIRECT_ACK(ack), .oPIPELINE_FLUSH(d_flush),
    .oBPRED_UPDATE_VALID(d_upd), .oBPRED_UPDATE_HIT(d_hit),
    .oPERF_HIT_CNT(d_hcnt), .oPERF_MISS_CNT(d_mcnt)
  );

  execute_jump_redirect #(.FLUSH_DRAIN_CYCLES(DRAIN_N), .CNT_W(4)) u_sat (
    .iCLOCK(clk), .inRESET(rst_n), .iRESET_SYNC(rs), .iEVENT_HOLD(ev_hold), .iEVENT_END(ev_end),
    .iPREV_PREDICT_ENA(p_ena), .iPREV_PREDICT_HIT(p_hit), .iPREV_JUMP_VALID(jv),
    .iPREV_JUMP_ADDR(jaddr), .iPREV_NORMAL_JUMP_INST(njump), .iPREV_TYPE_BRANCH_VALID(t_br),
    .iPREV_TYPE_BRANCH_IB_VALID(t_ib), .iPREV_TYPE_SYSREG_IDT_VALID(t_idt),
    .iPREV_TYPE_SYSREG_PDT_VALID(t_pdt), .iPREV_TYPE_SYSREG_PSR_VALID(t_psr),
    .oPREV_BUSY(s_busy), .oFETCH_REDIRECT_VALID(s_valid), .oFETCH_REDIRECT_ADDR(s_addr),
    .oFETCH_REDIRECT_KIND(s_kind), .iFETCH_REDIRECT_ACK(ack), .oPIPELINE_FLUSH(s_flush),
    .oBPRED_UPDATE_VALID(s_upd), .oBPRED_UPDATE_HIT(s_hit),
    .oPERF_HIT_CNT(s_hcnt), .oPERF_MISS_CNT(s_mcnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned sat4(input int unsigned v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic model_reset();
    m_red = 0; m_rec = 0; m_upd = 0; m_hit = 0; m_drain = 0;
    m_addr = '0; m_kind = '0; m_hits = 0; m_miss = 0;
  endtask

  // Apply one clock edge's worth of rules to the model, using the inputs present at that edge.
  task automatic model_edge();
    bit idle, req;
    idle = !m_red && (m_drain == 0) && !m_rec;
    req  = jv || t_ib || t_idt || t_pdt || t_psr;
    m_upd = 0; m_hit = 0;
    if (rs) begin
      model_reset();
    end else if (ev_hold || ev_end) begin
      m_red = 0; m_rec = 0; m_drain = 0; m_addr = '0; m_kind = '0;
    end else if (idle) begin
      if (p_ena && !njump) begin
        m_upd = 1; m_hit = p_hit;
        if (p_hit) m_hits++; else m_miss++;
      end
      if (req) begin
        m_red  = 1;
        m_addr = jaddr;
        m_kind = t_psr ? 3'd4 : t_pdt ? 3'd3 : t_idt ? 3'd2 : t_ib ? 3'd1 : 3'd0;
      end
    end else if (m_red) begin
      if (ack) begin m_red = 0; m_drain = DRAIN_N; end
    end else if (m_drain > 0) begin
      m_drain--;
      if (m_drain == 0) m_rec = 1;
    end else begin
      m_rec = 0;
    end
  endtask

  task automatic compare_all();
    bit eflush;
    eflush = m_red || (m_drain > 0);
    check("busy",  d_busy,  eflush);
    check("valid", d_valid, m_red);
    check("flush", d_flush, eflush);
    check("addr",  d_addr,  m_addr);
    check("kind",  d_kind,  m_kind);
    check("upd",   d_upd,   m_upd);
    check("uhit",  d_hit,   m_hit);
    check("hcnt",  d_hcnt,  m_hits);
    check("mcnt",  d_mcnt,  m_miss);
    check("sat_valid", s_valid, m_red);
    check("sat_flush", s_flush, eflush);
    check("sat_busy",  s_busy,  eflush);
    check("sat_addr",  s_addr,  m_addr);
    check("sat_kind",  s_kind,  m_kind);
    check("sat_upd",   s_upd,   m_upd);
    check("sat_uhit",  s_hit,   m_hit);
    check("sat_hcnt",  s_hcnt,  sat4(m_hits));
    check("sat_mcnt",  s_mcnt,  sat4(m_miss));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
    obs_valid += d_valid;
    obs_flush += d_flush;
    obs_upd   += d_upd;
  endtask

  task automatic clear_inputs();
    rs = 0; ev_hold = 0; ev_end = 0; p_ena = 0; p_hit = 0; jv = 0; njump = 0;
    t_br = 0; t_ib = 0; t_idt = 0; t_pdt = 0; t_psr = 0; ack = 0; jaddr = '0;
  endtask

  task automatic clear_obs();
    obs_valid = 0; obs_flush = 0; obs_upd = 0;
  endtask

  initial begin
    clear_inputs();
    rst_n = 0;
    model_reset();
    repeat (3) @(negedge clk);
    compare_all();
    rst_n = 1;
    cycle();

    // predictor training: 3 hits, 1 miss, 1 excluded unconditional jump
    clear_obs();
    p_ena = 1; p_hit = 1;
    repeat (3) cycle();
    p_hit = 0; cycle();
    njump = 1; p_hit = 1; cycle();
    clear_inputs(); cycle();
    check("train_pulses", obs_upd, 4);
    check("train_hcnt", d_hcnt, 3);
    check("train_mcnt", d_mcnt, 1);

    // branch redirect, ACK in third VALID cycle, then a discarded RECOVER-cycle input
    clear_obs();
    jv = 1; t_br = 1; jaddr = 32'h0000_1000;
    cycle();
    check("t1_addr", d_addr, 32'h1000);
    check("t1_kind", d_kind, 0);
    clear_inputs();
    repeat (2) cycle();
    ack = 1; cycle();
    ack = 0; repeat (2) cycle();
    check("t1_recover_busy", d_busy, 0);
    jv = 1; jaddr = 32'h0000_3000; cycle();
    check("t1_recover_ignored", d_valid, 0);
    clear_inputs(); cycle();
    check("t1_valid_cycles", obs_valid, 3);
    check("t1_flush_cycles", obs_flush, 3 + DRAIN_N);

    // IDT+PSR together, ACK in the first REDIRECT cycle
    clear_obs();
    t_idt = 1; t_psr = 1; jaddr = 32'hCAFE_0040;
    cycle();
    check("t2_kind", d_kind, 4);
    clear_inputs(); ack = 1; cycle();
    ack = 0; repeat (4) cycle();
    check("t2_valid_cycles", obs_valid, 1);
    check("t2_flush_cycles", obs_flush, 1 + DRAIN_N);

    // stale jump_req held high: one redirect per IDLE acceptance
    clear_obs();
    jv = 1; jaddr = 32'h0000_5000;
    cycle();
    ack = 1; cycle();
    ack = 0; repeat (3) cycle();
    check("t3_one_redirect", obs_valid, 1);
    cycle();
    check("t3_reaccept", obs_valid, 2);

    // hold mid-REDIRECT, then a stray ACK
    jv = 0; ev_hold = 1; cycle();
    check("t5_valid", d_valid, 0);
    check("t5_flush", d_flush, 0);
    check("t5_busy", d_busy, 0);
    check("t5_hcnt", d_hcnt, 3);
    ev_hold = 0; ack = 1; cycle();
    check("t5_ack_ignored", d_valid, 0);
    clear_inputs(); cycle();

    // saturation of 4-bit counters and synchronous clear
    p_ena = 1; p_hit = 1;
    repeat (20) cycle();
    check("t6_sat_hcnt", s_hcnt, 4'hF);
    check("t6_full_hcnt", d_hcnt, 23);
    clear_inputs(); rs = 1; cycle();
    rs = 0;
    check("t6_sync_clear", s_hcnt, 0);
    check("t6_sync_clear_full", d_hcnt, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rs      = ($urandom_range(99) < 1);
      ev_hold = ($urandom_range(99) < 3);
      ev_end  = ($urandom_range(99) < 2);
      p_ena   = ($urandom_range(99) < 50);
      p_hit   = ($urandom_range(99) < 50);
      njump   = ($urandom_range(99) < 30);
      jv      = ($urandom_range(99) < 20);
      t_br    = ($urandom_range(99) < 10);
      t_ib    = ($urandom_range(99) < 8);
      t_idt   = ($urandom_range(99) < 8);
      t_pdt   = ($urandom_range(99) < 8);
      t_psr   = ($urandom_range(99) < 8);
      ack     = ($urandom_range(99) < 40);
      jaddr   = $urandom;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
